ets_sweep_ctrl: RTL and testbench



---
 rtl/ets_sweep_ctrl.sv | 266 ++++++++++++++++++++++++++
 tb/tb_ets_sweep_ctrl.sv | 400 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ets_sweep_ctrl.sv
// ets_sweep_ctrl: equivalent-time sampling sweep controller.
// Steps an MMCM dynamic phase shifter through num_steps phase points. At each
// point it counts comparator hits per channel over num_samples cycles. Each
// result is then handed out over a valid/ready port.
//
// Optional build macro: ETS_SWEEP_PS_TIMEOUT_EN
//   defined   - waiting for ps_done is bounded by TO_CYC cycles; on expiry the
//               sweep ends in IDLE with the sticky err flag set.
//   undefined - ps_done is waited for indefinitely and err is tied low.
//
// Result handshake: res_valid rises when a result is ready. Once up, res_valid,
// res_step and res_count hold steady until a rising edge sees
// res_valid && res_ready. That edge is the transfer. res_valid is low on the
// following cycle. An abort withdraws res_valid in the same cycle, so no
// transfer happens.
//
// state_dbg mirrors the FSM state encoding for observation.
module ets_sweep_ctrl #(
    parameter int NCH        = 4,
    parameter int CNT_W      = 16,
    parameter int STEP_W     = 10,
    parameter int SETTLE_CYC = 8,
    parameter int TO_CYC     = 1024
) (
    input  logic                    free_run_clk,
    input  logic                    free_run_rst_n,
    input  logic                    start,
    input  logic                    abort,
    input  logic                    dir,
    input  logic [STEP_W-1:0]       num_steps,
    input  logic [CNT_W-1:0]        num_samples,
    input  logic [NCH-1:0]          cmp_data,
    output logic                    ps_en,
    output logic                    ps_incdec,
    input  logic                    ps_done,
    output logic                    busy,
    output logic                    done,
    output logic                    err,
    output logic                    res_valid,
    input  logic                    res_ready,
    output logic [STEP_W-1:0]       res_step,
    output logic [NCH*CNT_W-1:0]    res_count,
    output logic [2:0]              state_dbg
);

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        ACCUM      = 3'd1,
        OUTPUT     = 3'd2,
        SHIFT      = 3'd3,
        WAIT_PS    = 3'd4,
        SETTLE     = 3'd5,
        ABORT_WAIT = 3'd6
    } state_t;

    localparam int SET_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;

    state_t              state;
    state_t              state_nxt;

    logic                dir_q;
    logic [STEP_W-1:0]   steps_q;
    logic [CNT_W-1:0]    samples_q;
    logic [STEP_W-1:0]   step;
    logic [CNT_W-1:0]    smp_cnt;
    logic [SET_W-1:0]    settle_cnt;
    logic [CNT_W-1:0]    cnt [NCH];

    logic                start_acc;
    logic                xfer;
    logic                last_step;
    logic                set_done;

`ifdef ETS_SWEEP_PS_TIMEOUT_EN
    localparam int TO_W = (TO_CYC > 1) ? $clog2(TO_CYC) : 1;
    logic [TO_W-1:0]     to_cnt;
    logic                to_hit;
    logic                timeout;
    assign to_hit = (to_cnt == TO_W'(TO_CYC - 1));
`endif

    assign last_step = (step == steps_q - STEP_W'(1));
    assign busy      = (state != IDLE);
    assign ps_incdec = dir_q;
    assign res_step  = step;
    assign state_dbg = state;

    // Pack the per-channel hit counters onto the flat result bus.
    always_comb begin
        res_count = '0;
        for (int i = 0; i < NCH; i++) begin
            res_count[i*CNT_W +: CNT_W] = cnt[i];
        end
    end

    // State register.
    always_ff @(posedge free_run_clk or negedge free_run_rst_n) begin
        if (!free_run_rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic and per-state strobes; abort outranks every other event.
    always_comb begin
        state_nxt = state;
        ps_en     = 1'b0;
        res_valid = 1'b0;
        start_acc = 1'b0;
        xfer      = 1'b0;
        set_done  = 1'b0;
`ifdef ETS_SWEEP_PS_TIMEOUT_EN
        timeout   = 1'b0;
`endif
        case (state)
            IDLE: begin
                if (start && !abort) begin
                    start_acc = 1'b1;
                    if (num_steps == '0) begin
                        set_done = 1'b1;
                    end else if (num_samples == '0) begin
                        state_nxt = OUTPUT;
                    end else begin
                        state_nxt = ACCUM;
                    end
                end
            end
            ACCUM: begin
                if (abort) begin
                    state_nxt = IDLE;
                end else if (smp_cnt == samples_q - CNT_W'(1)) begin
                    state_nxt = OUTPUT;
                end
            end
            OUTPUT: begin
                if (abort) begin
                    state_nxt = IDLE;
                end else begin
                    res_valid = 1'b1;
                    if (res_ready) begin
                        xfer = 1'b1;
                        if (last_step) begin
                            set_done  = 1'b1;
                            state_nxt = IDLE;
                        end else begin
                            state_nxt = SHIFT;
                        end
                    end
                end
            end
            SHIFT: begin
                // ps_en is suppressed when aborting here so that no shift is
                // left outstanding while the controller sits in IDLE.
                if (abort) begin
                    state_nxt = IDLE;
                end else begin
                    ps_en     = 1'b1;
                    state_nxt = WAIT_PS;
                end
            end
            WAIT_PS: begin
                if (abort) begin
                    state_nxt = ps_done ? IDLE : ABORT_WAIT;
                end else if (ps_done) begin
                    state_nxt = SETTLE;
`ifdef ETS_SWEEP_PS_TIMEOUT_EN
                end else if (to_hit) begin
                    timeout   = 1'b1;
                    state_nxt = IDLE;
`endif
                end
            end
            SETTLE: begin
                if (abort) begin
                    state_nxt = IDLE;
                end else if (settle_cnt == SET_W'(SETTLE_CYC - 1)) begin
                    state_nxt = (samples_q == '0) ? OUTPUT : ACCUM;
                end
            end
            ABORT_WAIT: begin
                // The shift in flight must complete before a new sweep may
                // request another one, so a repeated abort does not exit here.
                if (ps_done) begin
                    state_nxt = IDLE;
`ifdef ETS_SWEEP_PS_TIMEOUT_EN
                end else if (to_hit) begin
                    timeout   = 1'b1;
                    state_nxt = IDLE;
`endif
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Sweep parameters, step index, done pulse and cycle counters.
    always_ff @(posedge free_run_clk or negedge free_run_rst_n) begin
        if (!free_run_rst_n) begin
            dir_q      <= 1'b0;
            steps_q    <= '0;
            samples_q  <= '0;
            step       <= '0;
            smp_cnt    <= '0;
            settle_cnt <= '0;
            done       <= 1'b0;
        end else begin
            done <= set_done;
            if (start_acc) begin
                dir_q     <= dir;
                steps_q   <= num_steps;
                samples_q <= num_samples;
                step      <= '0;
            end else if (xfer && !last_step) begin
                step <= step + STEP_W'(1);
            end
            smp_cnt    <= (state == ACCUM) ? smp_cnt + CNT_W'(1) : '0;
            settle_cnt <= (state == SETTLE) ? settle_cnt + SET_W'(1) : '0;
        end
    end

    // Per-channel saturating hit counters, cleared at sweep start and between steps.
    always_ff @(posedge free_run_clk or negedge free_run_rst_n) begin
        if (!free_run_rst_n) begin
            for (int i = 0; i < NCH; i++) begin
                cnt[i] <= '0;
            end
        end else if (start_acc || (xfer && !last_step)) begin
            for (int i = 0; i < NCH; i++) begin
                cnt[i] <= '0;
            end
        end else if (state == ACCUM && !abort) begin
            for (int i = 0; i < NCH; i++) begin
                if (cmp_data[i] && (cnt[i] != {CNT_W{1'b1}})) begin
                    cnt[i] <= cnt[i] + CNT_W'(1);
                end
            end
        end
    end

`ifdef ETS_SWEEP_PS_TIMEOUT_EN
    // Phase-shift wait timer (spans WAIT_PS and ABORT_WAIT) and the sticky error flag.
    always_ff @(posedge free_run_clk or negedge free_run_rst_n) begin
        if (!free_run_rst_n) begin
            to_cnt <= '0;
            err    <= 1'b0;
        end else begin
            if (state == WAIT_PS || state == ABORT_WAIT) begin
                to_cnt <= to_cnt + TO_W'(1);
            end else begin
                to_cnt <= '0;
            end
            if (start_acc) begin
                err <= 1'b0;
            end else if (timeout) begin
                err <= 1'b1;
            end
        end
    end
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_ets_sweep_ctrl.sv
// tb_ets_sweep_ctrl: self-checking bench for ets_sweep_ctrl.
// Expected results are pushed into exp_q when a sweep is launched. They are
// popped when a result transfer is seen on the res_valid/res_ready port.
module tb_ets_sweep_ctrl;

    localparam int NCH        = 4;
    localparam int CNT_W      = 16;
    localparam int STEP_W     = 10;
    localparam int SETTLE_CYC = 8;
    localparam int TO_CYC     = 16;
    localparam int RW         = STEP_W + NCH*CNT_W;

    logic                 free_run_clk;
    logic                 free_run_rst_n;
    logic                 start;
    logic                 abort;
    logic                 dir;
    logic [STEP_W-1:0]    num_steps;
    logic [CNT_W-1:0]     num_samples;
    logic [NCH-1:0]       cmp_data;
    logic                 ps_en;
    logic                 ps_incdec;
    logic                 ps_done;
    logic                 busy;
    logic                 done;
    logic                 err;
    logic                 res_valid;
    logic                 res_ready;
    logic [STEP_W-1:0]    res_step;
    logic [NCH*CNT_W-1:0] res_count;
    logic [2:0]           state_dbg;

    logic [RW-1:0]        exp_q[$];
    int                   total;
    int                   bad;
    int                   done_cnt;
    int                   psen_cnt;
    int                   done0;
    int                   psen0;
    logic                 ps_out;
    logic                 exp_dir;
    logic [NCH-1:0]       cur_pat;
    int                   rdy_mode;
    logic                 auto_ps;
    logic                 glitch;
    int                   ps_delay;

    ets_sweep_ctrl #(
        .NCH(NCH), .CNT_W(CNT_W), .STEP_W(STEP_W),
        .SETTLE_CYC(SETTLE_CYC), .TO_CYC(TO_CYC)
    ) dut (
        .free_run_clk(free_run_clk),
        .free_run_rst_n(free_run_rst_n),
        .start(start),
        .abort(abort),
        .dir(dir),
        .num_steps(num_steps),
        .num_samples(num_samples),
        .cmp_data(cmp_data),
        .ps_en(ps_en),
        .ps_incdec(ps_incdec),
        .ps_done(ps_done),
        .busy(busy),
        .done(done),
        .err(err),
        .res_valid(res_valid),
        .res_ready(res_ready),
        .res_step(res_step),
        .res_count(res_count),
        .state_dbg(state_dbg)
    );

    // Clock and watchdog.
    initial free_run_clk = 1'b0;
    always #5 free_run_clk = ~free_run_clk;

    initial begin
        #(95000 * 10);
        $display("FAIL watchdog: simulation did not finish, got running expected finished");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference result: channel i counts every sample when its pattern bit is set.
    function automatic logic [RW-1:0] model(input int stp, input logic [NCH-1:0] pat, input int samples);
        logic [NCH*CNT_W-1:0] c;
        int                   sat;
        c   = '0;
        sat = (samples > 65535) ? 65535 : samples;
        for (int i = 0; i < NCH; i++) begin
            c[i*CNT_W +: CNT_W] = pat[i] ? CNT_W'(sat) : '0;
        end
        return {STEP_W'(stp), c};
    endfunction

    // Ready driver: 0 = held low, 1 = held high, 2 = random each cycle.
    initial begin
        res_ready = 1'b1;
        forever begin
            @(posedge free_run_clk);
            #1;
            case (rdy_mode)
                0:       res_ready = 1'b0;
                1:       res_ready = 1'b1;
                default: res_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // MMCM model: answers ps_en with a ps_done pulse ps_delay cycles later and,
    // with glitch set, corrupts cmp_data for exactly the settle window.
    initial begin
        ps_done = 1'b0;
        forever begin
            @(negedge free_run_clk);
            if (ps_en && auto_ps) begin
                repeat (ps_delay) @(posedge free_run_clk);
                #1 ps_done = 1'b1;
                @(posedge free_run_clk);
                #1 ps_done = 1'b0;
                if (glitch) begin
                    cmp_data = ~cur_pat;
                    repeat (SETTLE_CYC) @(posedge free_run_clk);
                    #1 cmp_data = cur_pat;
                end
            end
        end
    end

    // Monitor and scoreboard: pulse counting, shift protocol and result compare.
    initial begin
        done_cnt = 0;
        psen_cnt = 0;
        ps_out   = 1'b0;
        forever begin
            @(negedge free_run_clk);
            if (free_run_rst_n) begin
                if (done) done_cnt++;
                if (ps_done) ps_out = 1'b0;
                if (ps_en) begin
                    psen_cnt++;
                    check("ps_overlap", 128'(ps_out), 128'(0));
                    check("ps_incdec", 128'(ps_incdec), 128'(exp_dir));
                    ps_out = 1'b1;
                end
                if (res_valid && res_ready) begin
                    check("result_expected", 128'(exp_q.size() != 0), 128'(1));
                    if (exp_q.size() != 0) begin
                        check("result", 128'({res_step, res_count}), 128'(exp_q.pop_front()));
                    end
                end
            end
        end
    end

    task automatic start_sweep(input int steps, input int samples, input logic [NCH-1:0] pat,
                               input logic d, input int npush);
        for (int s = 0; s < npush; s++) exp_q.push_back(model(s, pat, samples));
        exp_dir = d;
        cur_pat = pat;
        psen0   = psen_cnt;
        done0   = done_cnt;
        @(posedge free_run_clk);
        #1;
        start       = 1'b1;
        dir         = d;
        num_steps   = STEP_W'(steps);
        num_samples = CNT_W'(samples);
        cmp_data    = pat;
        if (steps > 0) begin
            // A second start with different settings while busy must be ignored.
            @(posedge free_run_clk);
            #1;
            num_steps   = '0;
            num_samples = '0;
            dir         = ~d;
        end
        @(posedge free_run_clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int n;
        n = 0;
        while (done_cnt == done0 && n < budget) begin
            @(negedge free_run_clk);
            n++;
        end
        check("done_seen", 128'(done_cnt != done0), 128'(1));
    endtask

    task automatic end_checks(input int steps);
        repeat (3) @(negedge free_run_clk);
        check("ps_en_pulses", 128'(psen_cnt - psen0), 128'(steps - 1));
        check("done_pulses", 128'(done_cnt - done0), 128'(1));
        check("queue_empty", 128'(exp_q.size()), 128'(0));
        check("idle_busy", 128'(busy), 128'(0));
    endtask

    task automatic run_sweep(input int steps, input int samples, input logic [NCH-1:0] pat,
                             input logic d, input int budget);
        start_sweep(steps, samples, pat, d, steps);
        wait_done(budget);
        end_checks(steps);
    endtask

    initial begin
        logic [RW-1:0]        mword;
        logic [NCH*CNT_W-1:0] hold_cnt;
        int                   n;
        total          = 0;
        bad            = 0;
        free_run_rst_n = 1'b0;
        start          = 1'b0;
        abort          = 1'b0;
        dir            = 1'b0;
        num_steps      = '0;
        num_samples    = '0;
        cmp_data       = '0;
        cur_pat        = '0;
        exp_dir        = 1'b0;
        rdy_mode       = 1;
        auto_ps        = 1'b1;
        glitch         = 1'b0;
        ps_delay       = 5;

        // Reset values.
        repeat (3) @(negedge free_run_clk);
        check("rst_busy", 128'(busy), 128'(0));
        check("rst_done", 128'(done), 128'(0));
        check("rst_err", 128'(err), 128'(0));
        check("rst_valid", 128'(res_valid), 128'(0));
        check("rst_ps_en", 128'(ps_en), 128'(0));
        check("rst_incdec", 128'(ps_incdec), 128'(0));
        check("rst_step", 128'(res_step), 128'(0));
        check("rst_count", 128'(res_count), 128'(0));
        check("rst_state", 128'(state_dbg), 128'(0));
        @(posedge free_run_clk);
        #1 free_run_rst_n = 1'b1;
        repeat (2) @(negedge free_run_clk);
        check("post_rst_done", 128'(done), 128'(0));

        // Reference sweep: 3 steps, 10 samples, pattern 0101, ps_done after 5 cycles.
        glitch = 1'b1;
        run_sweep(3, 10, 4'b0101, 1'b1, 600);

        // Zero steps: done one cycle after start, nothing else.
        psen0 = psen_cnt;
        done0 = done_cnt;
        @(posedge free_run_clk);
        #1;
        start     = 1'b1;
        num_steps = '0;
        @(posedge free_run_clk);
        #1 start = 1'b0;
        @(negedge free_run_clk);
        check("zero_done", 128'(done), 128'(1));
        check("zero_busy", 128'(busy), 128'(0));
        @(negedge free_run_clk);
        check("zero_done_drop", 128'(done), 128'(0));
        check("zero_ps_en", 128'(psen_cnt - psen0), 128'(0));

        // Randomised sweeps with random backpressure and shift latency.
        rdy_mode = 2;
        for (int k = 0; k < 4; k++) begin
            ps_delay = $urandom_range(1, 6);
            run_sweep($urandom_range(1, 4), $urandom_range(0, 20), NCH'($urandom_range(0, 15)),
                      1'($urandom_range(0, 1)), 1000);
        end
        rdy_mode = 1;

        // Zero samples: results carry zero counts.
        run_sweep(2, 0, 4'b1111, 1'b1, 400);

        // Backpressure: result held steady for 20 cycles, no shift until transfer.
        rdy_mode = 0;
        start_sweep(2, 5, 4'b1011, 1'b1, 2);
        n = 0;
        while (!res_valid && n < 100) begin
            @(negedge free_run_clk);
            n++;
        end
        check("hold_reach", 128'(res_valid), 128'(1));
        mword    = model(0, 4'b1011, 5);
        hold_cnt = mword[NCH*CNT_W-1:0];
        psen0    = psen_cnt;
        repeat (20) begin
            @(negedge free_run_clk);
            check("hold_valid", 128'(res_valid), 128'(1));
            check("hold_count", 128'(res_count), 128'(hold_cnt));
        end
        check("hold_no_ps", 128'(psen_cnt - psen0), 128'(0));
        psen0    = psen_cnt - 0;
        rdy_mode = 1;
        wait_done(400);
        repeat (3) @(negedge free_run_clk);
        check("hold_ps_en", 128'(psen_cnt - psen0), 128'(1));
        check("hold_queue", 128'(exp_q.size()), 128'(0));

        // Full-scale sample count.
        glitch = 1'b0;
        run_sweep(1, 65535, 4'b1111, 1'b0, 70000);

        // Abort while waiting for ps_done: wait out the shift, then IDLE.
        auto_ps = 1'b0;
        start_sweep(2, 4, 4'b0110, 1'b1, 1);
        n = 0;
        while (!ps_en && n < 200) begin
            @(negedge free_run_clk);
            n++;
        end
        check("abort_ps_seen", 128'(ps_en), 128'(1));
        @(posedge free_run_clk);
        #1 abort = 1'b1;
        @(posedge free_run_clk);
        #1 abort = 1'b0;
        repeat (5) begin
            @(negedge free_run_clk);
            check("abort_busy", 128'(busy), 128'(1));
        end
        @(posedge free_run_clk);
        #1 ps_done = 1'b1;
        @(posedge free_run_clk);
        #1 ps_done = 1'b0;
        @(negedge free_run_clk);
        check("abort_idle", 128'(busy), 128'(0));
        repeat (3) @(negedge free_run_clk);
        check("abort_no_done", 128'(done_cnt - done0), 128'(0));
        check("abort_queue", 128'(exp_q.size()), 128'(0));
        check("abort_ps_en", 128'(psen_cnt - psen0), 128'(1));

        // Abort during accumulation: IDLE on the next cycle, no result.
        start_sweep(2, 30, 4'b1001, 1'b0, 0);
        repeat (3) @(posedge free_run_clk);
        #1 abort = 1'b1;
        @(negedge free_run_clk);
        check("abort_acc_busy", 128'(busy), 128'(1));
        @(posedge free_run_clk);
        #1 abort = 1'b0;
        @(negedge free_run_clk);
        check("abort_acc_idle", 128'(busy), 128'(0));
        check("abort_acc_valid", 128'(res_valid), 128'(0));
        repeat (40) @(negedge free_run_clk);
        check("abort_acc_no_done", 128'(done_cnt - done0), 128'(0));
        check("abort_acc_err", 128'(err), 128'(0));

        // ps_done withheld.
`ifdef ETS_SWEEP_PS_TIMEOUT_EN
        start_sweep(2, 3, 4'b0011, 1'b1, 1);
`else
        start_sweep(2, 3, 4'b0011, 1'b1, 2);
`endif
        n = 0;
        while (!ps_en && n < 200) begin
            @(negedge free_run_clk);
            n++;
        end
        check("to_ps_seen", 128'(ps_en), 128'(1));
        repeat (20) @(negedge free_run_clk);
`ifdef ETS_SWEEP_PS_TIMEOUT_EN
        check("to_err", 128'(err), 128'(1));
        check("to_busy", 128'(busy), 128'(0));
        check("to_no_done", 128'(done_cnt - done0), 128'(0));
        check("to_queue", 128'(exp_q.size()), 128'(0));
        ps_out = 1'b0;
        @(posedge free_run_clk);
        #1;
        start     = 1'b1;
        num_steps = '0;
        @(posedge free_run_clk);
        #1 start = 1'b0;
        @(negedge free_run_clk);
        check("to_err_clear", 128'(err), 128'(0));
        check("to_restart_done", 128'(done), 128'(1));
`else
        check("wait_busy", 128'(busy), 128'(1));
        check("wait_err", 128'(err), 128'(0));
        @(posedge free_run_clk);
        #1 ps_done = 1'b1;
        @(posedge free_run_clk);
        #1 ps_done = 1'b0;
        wait_done(400);
        end_checks(2);
`endif
        auto_ps = 1'b1;

        repeat (5) @(negedge free_run_clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
